aes128_round_ctrl: RTL and testbench

//  Iterative AES-128 encryption sequencer: owns the 128-bit state register and the round-key register.

---
 rtl/aes128_round_ctrl_pkg.sv | 104 ++++++++++
 rtl/aes128_round_ctrl_key_step.sv | 27 ++
 rtl/aes128_round_ctrl.sv | 81 ++++++++
 tb/tb_aes128_round_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_round_ctrl_pkg.sv
// AES-128 sequencer shared constants, FSM type and byte-level round functions.
// Byte i of a block lives at bits [127-8*i -: 8]; bytes are column-major.
package aes128_round_ctrl_pkg;

  localparam int NR = 10;
  localparam int DATA_W = 128;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] =
          s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] =
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] =
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] =
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] =
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_round_ctrl_key_step.sv
// One round of AES-128 key expansion: (rk, rcon) -> next round key.
// Combinational; four sbox lookups on the rotated last word.
module aes_key_step
  import aes128_round_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] rk,
  input  logic [7:0]        rc,
  output logic [DATA_W-1:0] rk_next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    {w0, w1, w2, w3} = rk;
    t = {sbox(w3[23:16]), sbox(w3[15:8]),
         sbox(w3[7:0]), sbox(w3[31:24])}
        ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    rk_next = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption sequencer, one round per clock.
// Owns state and round-key registers; start/done handshake to the regfile.
module aes128_round_ctrl
  import aes128_round_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] key_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        round_idx
);

  state_t fsm;

  logic [DATA_W-1:0] st;
  logic [DATA_W-1:0] rk;
  logic [DATA_W-1:0] rk_next;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] rnd;
  logic [7:0]        rc;
  logic              last;

  assign rc = rcon(round_idx);

  aes_key_step u_key_step (
    .rk      (rk),
    .rc      (rc),
    .rk_next (rk_next)
  );

  // Final round skips mixColumns.
  always_comb begin
    sr   = shift_rows(sub_bytes(st));
    last = (round_idx == 4'(NR));
    rnd  = (last ? sr : mix_columns(sr)) ^ rk_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      data_out  <= '0;
      round_idx <= '0;
      st        <= '0;
      rk        <= '0;
    end else begin
      done <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (start) begin
            st        <= data_in ^ key_in;
            rk        <= key_in;
            round_idx <= 4'd1;
            busy      <= 1'b1;
            fsm       <= RUN;
          end
        end
        RUN: begin
          st <= rnd;
          rk <= rk_next;
          if (last) begin
            data_out  <= rnd;
            done      <= 1'b1;
            busy      <= 1'b0;
            round_idx <= '0;
            fsm       <= IDLE;
          end else begin
            round_idx <= round_idx + 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Scoreboard bench for aes128_round_ctrl: directed FIPS-197 vectors plus
// random traffic against a GF(2^8)-arithmetic AES-128 reference.
module tb_aes128_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] data_in;
  logic         busy;
  logic         done;
  logic [127:0] data_out;
  logic [3:0]   round_idx;

  always #5 clk = ~clk;

  aes128_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out),
    .round_idx (round_idx)
  );

  typedef struct {
    logic [127:0] ct;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           last_acc = -100;
  logic [127:0] held = '0;
  int           errs = 0;
  int           checks = 0;
  logic [7:0]   sbt [256];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Sbox from first principles: multiplicative inverse, then affine map.
  task automatic build_sbox();
    logic [7:0] p;
    for (int i = 0; i < 256; i++) begin
      p = 8'h01;
      for (int j = 0; j < 254; j++) p = gmul(p, 8'(i));
      sbt[i] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3)
               ^ rotl8(p, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(logic [127:0] key,
                                           logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc = 8'h01;
    logic [31:0]  x;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      x = w[i-1];
      if (i % 4 == 0) begin
        x = {x[23:0], x[31:24]};
        x = {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]}
            ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ x;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          s[rr+4*c] = t[rr+4*((c+rr)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
          s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
        end
      end
      for (int i = 0; i < 16; i++)
        s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic chk(string n, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h at cycle %0d", n, a, e, cyc);
    end
  endtask

  // One cycle of stimulus; the model decides acceptance for the next edge.
  task automatic drive(input logic r, input logic s,
                       input logic [127:0] k, input logic [127:0] p,
                       input logic kn, input logic [127:0] kct);
    int e;
    @(negedge clk);
    rst_n = r;
    start = s;
    key_in = k;
    data_in = p;
    e = cyc + 1;
    if (!r) begin
      q.delete();
      last_acc = -100;
      held = '0;
    end else if (s && e >= last_acc + 11) begin
      last_acc = e;
      q.push_back('{ct: (kn ? kct : aes_ref(k, p)), cyc: e + 10});
    end
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic       eb, ed;
    logic [3:0] eri;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
      eb  = (cyc >= last_acc) && (cyc < last_acc + 10);
      eri = eb ? 4'(cyc - last_acc + 1) : 4'd0;
      ed  = (q.size() > 0) && (q[0].cyc == cyc);
      chk("busy", busy, eb);
      chk("round_idx", round_idx, eri);
      chk("done", done, ed);
      if (ed) begin
        held = q[0].ct;
        void'(q.pop_front());
      end
      chk("data_out", data_out, held);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    build_sbox();
    rst_n = 1'b0;
    start = 1'b0;
    key_in = '0;
    data_in = '0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    idle(3);

    // C.1 vector with a start pulse during round 4 that must be ignored
    drive(1'b1, 1'b1, K1, P1, 1'b1, C1);
    idle(3);
    drive(1'b1, 1'b1, K1, '1, 1'b1, C1);
    idle(12);

    drive(1'b1, 1'b1, K2, P2, 1'b1, C2);
    idle(12);

    // all-zero block, then start held high: back-to-back at 11 cycles
    drive(1'b1, 1'b1, '0, '0, 1'b1, C0);
    repeat (12) drive(1'b1, 1'b1, K2, P2, 1'b1, C2);
    idle(12);

    // reset at round 5 aborts the block
    drive(1'b1, 1'b1, K2, P2, 1'b1, C2);
    idle(4);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    idle(14);
    drive(1'b1, 1'b1, K2, P2, 1'b1, C2);
    idle(12);

    // random traffic with occasional reset
    repeat (500) begin
      if ($urandom_range(0, 299) == 0)
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
      else
        drive(1'b1, ($urandom_range(0, 2) == 0),
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              1'b0, '0);
    end

    n = 0;
    while (q.size() > 0 && n < 40) begin
      idle(1);
      n++;
    end
    idle(2);
    chk("drain", 128'(q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
